// File: rtl/regfile_mp.sv
// Multi-port register file: N combinational read ports, ALU and load write ports
// with write-first bypass, and a per-register pending-load scoreboard.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NREAD  = 3,
    parameter int unsigned PC_IDX = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_a,
    input  logic [ADDR_W-1:0]         wa_a,
    input  logic [DATA_W-1:0]         wd_a,
    input  logic                      we_l,
    input  logic [ADDR_W-1:0]         wa_l,
    input  logic [DATA_W-1:0]         wd_l,
    input  logic                      lset,
    input  logic [ADDR_W-1:0]         lset_addr,
    input  logic [DATA_W-1:0]         pc_in,
    input  logic [NREAD*ADDR_W-1:0]   ra,
    output logic [NREAD*DATA_W-1:0]   rd,
    output logic [NREAD-1:0]          rd_busy,
    output logic                      any_busy
);

    localparam int unsigned NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   sel_a;
    logic [NREG-1:0]   sel_l;
    logic [NREG-1:0]   sel_set;

    // Per-register write/set decode; the PC alias never decodes so it has no state.
    always_comb begin
        sel_a   = '0;
        sel_l   = '0;
        sel_set = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (ADDR_W'(r) != PC_A) begin
                sel_a[r]   = we_a && (wa_a == ADDR_W'(r));
                sel_l[r]   = we_l && (wa_l == ADDR_W'(r));
                sel_set[r] = lset && (lset_addr == ADDR_W'(r));
            end
        end
    end

    // ALU port wins a same-address collision; a new load set beats any clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
            pend <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (sel_a[r]) begin
                    mem[r] <= wd_a;
                end else if (sel_l[r]) begin
                    mem[r] <= wd_l;
                end
                if (sel_set[r]) begin
                    pend[r] <= 1'b1;
                end else if (sel_a[r] || sel_l[r]) begin
                    pend[r] <= 1'b0;
                end
            end
        end
    end

    // Read ports: PC alias, then ALU bypass, then load bypass, then storage.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            if (ra[i*ADDR_W +: ADDR_W] == PC_A) begin
                rd[i*DATA_W +: DATA_W] = pc_in;
            end else if (we_a && (wa_a == ra[i*ADDR_W +: ADDR_W])) begin
                rd[i*DATA_W +: DATA_W] = wd_a;
            end else if (we_l && (wa_l == ra[i*ADDR_W +: ADDR_W])) begin
                rd[i*DATA_W +: DATA_W] = wd_l;
            end else begin
                rd[i*DATA_W +: DATA_W] = mem[ra[i*ADDR_W +: ADDR_W]];
            end
            rd_busy[i] = pend[ra[i*ADDR_W +: ADDR_W]]
                         && (ra[i*ADDR_W +: ADDR_W] != PC_A)
                         && !(we_l && (wa_l == ra[i*ADDR_W +: ADDR_W]))
                         && !(we_a && (wa_a == ra[i*ADDR_W +: ADDR_W]));
        end
    end

    assign any_busy = |pend;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, reset corner sequence and random
// stimulus checked against an array-based model; a second 4-port 16-bit instance shares stimulus.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        we_a, we_l, lset;
    logic [3:0]  wa_a, wa_l, lset_addr;
    logic [31:0] wd_a, wd_l, pc_in;
    logic [11:0] ra;
    logic [95:0] rd;
    logic [2:0]  rd_busy;
    logic        any_busy;

    logic [15:0] wd_a2, wd_l2, pc_in2;
    logic [15:0] ra2;
    logic [63:0] rd2;
    logic [3:0]  rd_busy2;
    logic        any_busy2;

    assign wd_a2  = wd_a[15:0];
    assign wd_l2  = wd_l[15:0];
    assign pc_in2 = pc_in[15:0];

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_l(we_l), .wa_l(wa_l), .wd_l(wd_l),
        .lset(lset), .lset_addr(lset_addr), .pc_in(pc_in),
        .ra(ra), .rd(rd), .rd_busy(rd_busy), .any_busy(any_busy)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .NREAD(4), .PC_IDX(15)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a2),
        .we_l(we_l), .wa_l(wa_l), .wd_l(wd_l2),
        .lset(lset), .lset_addr(lset_addr), .pc_in(pc_in2),
        .ra(ra2), .rd(rd2), .rd_busy(rd_busy2), .any_busy(any_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we_a;
        logic [3:0]  wa_a;
        logic [31:0] wd_a;
        bit          we_l;
        logic [3:0]  wa_l;
        logic [31:0] wd_l;
        bit          lset;
        logic [3:0]  ls;
        logic [31:0] pc;
        logic [3:0]  ra [3];
        logic [31:0] erd [3];
        logic [2:0]  ebusy;
        bit          eany;
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: plain arrays updated from the written rules.
    logic [31:0] m_mem  [16];
    bit          m_pend [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [3:0] a);
        if (a == 4'd15) return pc_in;
        if (we_a && wa_a == a) return wd_a;
        if (we_l && wa_l == a) return wd_l;
        return m_mem[a];
    endfunction

    function automatic bit m_busy(input logic [3:0] a);
        if (a == 4'd15) return 1'b0;
        return m_pend[a] && !(we_l && wa_l == a) && !(we_a && wa_a == a);
    endfunction

    function automatic bit m_any();
        bit b = 1'b0;
        for (int r = 0; r < 16; r++) b = b | m_pend[r];
        return b;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 16; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    task automatic m_clock();
        for (int r = 0; r < 15; r++) begin
            bit wa = we_a && (wa_a == 4'(r));
            bit wl = we_l && (wa_l == 4'(r));
            if (wa) m_mem[r] = wd_a;
            else if (wl) m_mem[r] = wd_l;
            if (lset && lset_addr == 4'(r)) m_pend[r] = 1'b1;
            else if (wa || wl) m_pend[r] = 1'b0;
        end
    endtask

    task automatic model_check();
        logic [31:0] e;
        logic [3:0]  a;
        for (int i = 0; i < 3; i++) begin
            a = ra[i*4 +: 4];
            chk("model_rd", rd[i*32 +: 32], m_rd(a));
            chk("model_busy", 32'(rd_busy[i]), 32'(m_busy(a)));
        end
        chk("model_any", 32'(any_busy), 32'(m_any()));
        for (int i = 0; i < 4; i++) begin
            a = ra2[i*4 +: 4];
            e = m_rd(a);
            chk("w16_rd", 32'(rd2[i*16 +: 16]), 32'(e[15:0]));
            chk("w16_busy", 32'(rd_busy2[i]), 32'(m_busy(a)));
        end
        chk("w16_any", 32'(any_busy2), 32'(m_any()));
    endtask

    task automatic drive(input vec_t v);
        we_a = v.we_a; wa_a = v.wa_a; wd_a = v.wd_a;
        we_l = v.we_l; wa_l = v.wa_l; wd_l = v.wd_l;
        lset = v.lset; lset_addr = v.ls; pc_in = v.pc;
        ra   = {v.ra[2], v.ra[1], v.ra[0]};
        ra2  = 16'($urandom);
    endtask

    task automatic step(input vec_t v, input bit tab);
        @(negedge clk);
        drive(v);
        #1;
        if (tab) begin
            for (int i = 0; i < 3; i++) chk("tab_rd", rd[i*32 +: 32], v.erd[i]);
            chk("tab_busy", 32'(rd_busy), 32'(v.ebusy));
            chk("tab_any", 32'(any_busy), 32'(v.eany));
        end
        model_check();
        @(posedge clk);
        if (rst_n) m_clock();
    endtask

    task automatic add(input bit wea, input logic [3:0] waa, input logic [31:0] wda,
                       input bit wel, input logic [3:0] wal, input logic [31:0] wdl,
                       input bit ls, input logic [3:0] lsa, input logic [31:0] pc,
                       input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [2:0] eb, input bit ea);
        vec_t v;
        v.we_a = wea; v.wa_a = waa; v.wd_a = wda;
        v.we_l = wel; v.wa_l = wal; v.wd_l = wdl;
        v.lset = ls;  v.ls = lsa;   v.pc = pc;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
        v.erd[0] = e0; v.erd[1] = e1; v.erd[2] = e2;
        v.ebusy = eb; v.eany = ea;
        tv.push_back(v);
    endtask

    initial begin
        vec_t rv;
        logic [31:0] DB;
        DB = 32'hDEADBEEF;

        // Directed sequence, each row: stimulus then expected same-cycle outputs.
        add(0,0,0,     0,0,0,      0,0,  'h100, 0,15,3,  0,'h100,0,        3'b000,0);
        add(1,3,DB,    0,0,0,      0,0,  'h100, 3,15,1,  DB,'h100,0,       3'b000,0);
        add(0,0,0,     0,0,0,      0,0,  'h100, 3,3,0,   DB,DB,0,          3'b000,0);
        add(1,5,'h11,  1,5,'h22,   0,0,  'h100, 5,3,5,   'h11,DB,'h11,     3'b000,0);
        add(0,0,0,     0,0,0,      0,0,  'h100, 5,0,0,   'h11,0,0,         3'b000,0);
        add(0,0,0,     0,0,0,      1,7,  'h100, 7,5,3,   0,'h11,DB,        3'b000,0);
        add(0,0,0,     0,0,0,      0,0,  'h100, 7,7,3,   0,0,DB,           3'b011,1);
        add(0,0,0,     1,7,'h55,   0,0,  'h100, 7,0,7,   'h55,0,'h55,      3'b000,1);
        add(0,0,0,     0,0,0,      0,0,  'h100, 7,7,7,   'h55,'h55,'h55,   3'b000,0);
        add(0,0,0,     1,2,'h9,    1,2,  'h100, 2,7,0,   'h9,'h55,0,       3'b000,0);
        add(1,15,'h77, 0,0,0,      0,0,  'h200, 2,15,15, 'h9,'h200,'h200,  3'b001,1);
        add(0,0,0,     0,0,0,      0,0,  'h200, 15,2,3,  'h200,'h9,DB,     3'b010,1);
        add(0,0,0,     0,0,0,      1,15, 'h200, 15,2,2,  'h200,'h9,'h9,    3'b110,1);
        add(1,2,'h33,  0,0,0,      0,0,  'h200, 2,15,5,  'h33,'h200,'h11,  3'b000,1);
        add(0,0,0,     0,0,0,      0,0,  'h200, 2,2,15,  'h33,'h33,'h200,  3'b000,0);
        add(1,4,'h44,  0,0,0,      1,4,  'h200, 4,4,0,   'h44,'h44,0,      3'b000,0);
        add(0,0,0,     0,0,0,      1,1,  'h200, 4,1,15,  'h44,0,'h200,     3'b001,1);

        rst_n = 1'b0;
        we_a = 0; wa_a = 0; wd_a = 0; we_l = 0; wa_l = 0; wd_l = 0;
        lset = 0; lset_addr = 0; pc_in = 0; ra = 0; ra2 = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[k]) step(tv[k], 1'b1);

        // r1 and r4 pending; asynchronous reset in the middle of a cycle.
        @(negedge clk);
        we_a = 0; we_l = 0; lset = 0; pc_in = 'h300;
        ra = {4'd15, 4'd4, 4'd1};
        #1;
        chk("pre_rst_busy", 32'(rd_busy), 32'h3);
        chk("pre_rst_any", 32'(any_busy), 32'h1);
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_any", 32'(any_busy), 32'h0);
        chk("rst_any16", 32'(any_busy2), 32'h0);
        chk("rst_busy", 32'(rd_busy), 32'h0);
        chk("rst_rd1", rd[31:0], 32'h0);
        chk("rst_rd4", rd[63:32], 32'h0);
        chk("rst_pc", rd[95:64], 32'h300);
        @(negedge clk);
        we_l = 1; wa_l = 4'd1; wd_l = 'h66;
        @(negedge clk);
        we_l = 0;
        rst_n = 1'b1;
        #1;
        chk("rst_wr_ignored", rd[31:0], 32'h0);
        chk("rst_no_busy", 32'(rd_busy), 32'h0);
        @(negedge clk);
        we_l = 1; wa_l = 4'd1; wd_l = 'h77;
        #1;
        chk("post_rst_bypass", rd[31:0], 32'h77);
        chk("post_rst_busy", 32'(rd_busy), 32'h0);
        @(posedge clk);
        m_clock();
        @(negedge clk);
        we_l = 0;
        #1;
        chk("post_rst_store", rd[31:0], 32'h77);
        chk("post_rst_any", 32'(any_busy), 32'h0);
        model_check();

        // Random traffic against the model; small address range raises collision odds.
        for (int n = 0; n < 600; n++) begin
            rv.we_a = ($urandom_range(0, 2) == 0);
            rv.wa_a = 4'($urandom_range(0, 15));
            rv.wd_a = $urandom;
            rv.we_l = ($urandom_range(0, 2) == 0);
            rv.wa_l = (n % 3 == 0) ? rv.wa_a : 4'($urandom_range(0, 15));
            rv.wd_l = $urandom;
            rv.lset = ($urandom_range(0, 2) == 0);
            rv.ls   = (n % 5 == 0) ? rv.wa_l : 4'($urandom_range(0, 15));
            rv.pc   = $urandom;
            for (int i = 0; i < 3; i++) begin
                rv.ra[i]  = (i == 0 && n % 4 == 0) ? rv.wa_a : 4'($urandom_range(0, 15));
                rv.erd[i] = '0;
            end
            rv.ebusy = '0;
            rv.eany  = 1'b0;
            step(rv, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the next CPU generation. Replaces the single-write, two-read register file with:
- N combinational read ports;
- two write ports: ALU/execute writeback and load writeback;
- write-first bypass from both write ports to every read port;
- a per-register pending-load scoreboard that flags reads of registers whose load result has not yet returned.

Sits in the decode stage. It feeds operands and hazard flags to the pipeline control and keeps the PC-alias register convention.

## Interface
Parameters:
- DATA_W, 32, data width of each register
- ADDR_W, 4, register address width; 2**ADDR_W architectural indices
- NREAD, 3, number of read ports
- PC_IDX, 15, index that aliases the PC input; not stored

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- we_a  in  1  ALU write enable
- wa_a  in  ADDR_W  ALU write address
- wd_a  in  DATA_W  ALU write data
- we_l  in  1  load-writeback write enable
- wa_l  in  ADDR_W  load write address
- wd_l  in  DATA_W  load write data
- lset  in  1  load issued; mark lset_addr pending
- lset_addr  in  ADDR_W  destination of the issued load
- pc_in  in  DATA_W  value returned for reads of PC_IDX (PC+8)
- ra  in  NREAD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd  out  NREAD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
- rd_busy  out  NREAD  port i reads a register with an outstanding load
- any_busy  out  1  OR of all pending bits

## Operation
- Storage: 2**ADDR_W - 1 registers of DATA_W bits plus 2**ADDR_W pending bits. PC_IDX has no storage.
- Writes:
  - Writes to PC_IDX on either port are ignored.
  - When we_a and we_l target the same address in one cycle, the ALU port wins. The ALU instruction is younger.
- Read data for port i, in priority order:
  - ra_i == PC_IDX → pc_in.
  - Else we_a && wa_a == ra_i → wd_a.
  - Else we_l && wa_l == ra_i → wd_l.
  - Else stored value.
- Scoreboard, per address r, next pending value:
  - Set if lset && lset_addr == r. Set wins over any clear in the same cycle, because a new load supersedes.
  - Else cleared if (we_l && wa_l == r) or (we_a && wa_a == r).
  - Else unchanged.
  - lset to PC_IDX is ignored.
- rd_busy[i] = pending[ra_i] && !(we_l && wa_l == ra_i) && !(we_a && wa_a == ra_i).
  - A write this cycle is forwarded, so it does not stall.
  - rd_busy is always 0 for PC_IDX.
- any_busy reflects registered pending state only. No bypass.

## Timing
- Reads are fully combinational from ra, the write ports and pc_in. Zero-cycle latency.
- Register and pending updates take effect on the rising clk edge after the inputs are presented.
- Reset:
  - rst_n low asynchronously clears all registers and pending bits to 0.
  - During reset, rd = 0 for non-PC indices absent bypass, rd_busy = 0, any_busy = 0.
- Write enables during reset are ignored; storage is held at 0.
- First capture happens on the first rising edge after rst_n rises.
- Reset mid-operation discards all pending loads. A later we_l to a non-pending register writes normally.
- A lset and a we_l to the same address in one cycle: data is written and the pending bit remains set.

## Test plan
- Reset, then read all 16 indices with pc_in=0x100 → rd=0 except index 15 = 0x100; rd_busy=0; any_busy=0.
- we_a to r3 with 0xDEADBEEF, reading r3 in the same cycle → rd=0xDEADBEEF combinationally; next cycle, with we_a low, still 0xDEADBEEF.
- Simultaneous we_a(r5, 0x11) and we_l(r5, 0x22) → same-cycle read and stored value both = 0x11.
- lset r7; next cycle read r7 → rd_busy=1, any_busy=1. Then we_l r7=0x55 → that cycle rd_busy=0, rd=0x55. Next cycle pending is cleared.
- Same cycle lset r2 and we_l r2=0x9 → r2 stores 0x9 and remains pending. we_a r15=0x77 → no storage change; r15 still reads pc_in.
- Set pending on r1 and r4, pulse rst_n low mid-cycle → any_busy drops immediately, registers read 0. Re-run with NREAD=4, DATA_W=16 to check the parametrised slicing.
